// File: rtl/vram_port.sv
// vram_port: single-port video-RAM arbiter sharing one memory access per clock between video and CPU
// Ports:
//   clk_in, rst_in                      pixel clock, async active-high reset
//   vid_active, vid_addr -> vid_data    mode-generator fetch side (vid_active=1 means blanking)
//   cpu_addr/wdata/we/re -> cpu_wfull, cpu_rdata, cpu_rvalid   CPU side, buffered writes
//   mem_addr/wdata/we <- mem_rdata      memory side, outputs registered, read data one clock later
module vram_port #(
    parameter int AW       = 24,
    parameter int WF_DEPTH = 4
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          vid_active,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_data,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_re,
    output logic          cpu_wfull,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata
);
    localparam int PW = $clog2(WF_DEPTH);

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_DATA} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} tag_t;

    state_t        state_q, state_d;
    tag_t          tag_q, tag_d;
    logic          slot_q, slot_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          wfull_q, wfull_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic [7:0]    vid_data_q, vid_data_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic [AW-1:0] fifo_addr_q [WF_DEPTH];
    logic [7:0]    fifo_data_q [WF_DEPTH];
    logic          vid_slot, push, pop, issue_rd;

    always_comb begin
        vid_slot     = !vid_active && !slot_q;
        push         = cpu_we && !wfull_q;
        pop          = !vid_slot && count_q != '0;
        // reads wait for an empty FIFO so they observe every earlier write
        issue_rd     = !vid_slot && count_q == '0 && state_q == RD_REQ;
        slot_d       = vid_active ? 1'b0 : !slot_q;
        wr_ptr_d     = wr_ptr_q + PW'(push);
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        count_d      = count_q + (PW+1)'(push) - (PW+1)'(pop);
        wfull_d      = count_d == (PW+1)'(WF_DEPTH);
        mem_addr_d   = vid_slot ? vid_addr : pop ? fifo_addr_q[rd_ptr_q] : issue_rd ? cpu_addr : mem_addr_q;
        mem_wdata_d  = pop ? fifo_data_q[rd_ptr_q] : mem_wdata_q;
        mem_we_d     = pop;
        tag_d        = vid_slot ? TAG_VID : issue_rd ? TAG_CPU : TAG_NONE;
        // the tag of the access issued last clock steers this clock's mem_rdata
        vid_data_d   = tag_q == TAG_VID ? mem_rdata : vid_data_q;
        cpu_rdata_d  = tag_q == TAG_CPU ? mem_rdata : cpu_rdata_q;
        cpu_rvalid_d = tag_q == TAG_CPU;
        // the rvalid term stops a still-held cpu_re from restarting on its own completion cycle
        state_d      = state_q == IDLE   ? ((cpu_re && !cpu_rvalid_q) ? RD_REQ : IDLE) :
                       state_q == RD_REQ ? (issue_rd ? RD_DATA : RD_REQ) : IDLE;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            tag_q        <= TAG_NONE;
            slot_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wfull_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            vid_data_q   <= '0;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            slot_q       <= slot_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wfull_q      <= wfull_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            vid_data_q   <= vid_data_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
        end
    end

    // storage needs no reset: the pointers define which entries are live
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= cpu_addr;
            fifo_data_q[wr_ptr_q] <= cpu_wdata;
        end
    end

    assign vid_data   = vid_data_q;
    assign cpu_wfull  = wfull_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
endmodule

// File: tb/tb_vram_port.sv
// tb_vram_port: randomized scoreboard bench for vram_port against a behavioural memory/slot model
module tb_vram_port;
    localparam int AW  = 24;
    localparam int WFD = 4;

    logic          clk_in = 0, rst_in = 1, vid_active = 1, cpu_we = 0, cpu_re = 0;
    logic [AW-1:0] vid_addr = 0, cpu_addr = 0;
    logic [7:0]    cpu_wdata = 0, mem_rdata = 0;
    logic [7:0]    vid_data, cpu_rdata, mem_wdata;
    logic          cpu_wfull, cpu_rvalid, mem_we;
    logic [AW-1:0] mem_addr;

    vram_port #(.AW(AW), .WF_DEPTH(WFD)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .vid_active(vid_active), .vid_addr(vid_addr),
        .vid_data(vid_data), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_re(cpu_re), .cpu_wfull(cpu_wfull), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // physical memory attached to the DUT, and the CPU's program-order view of it
    logic [7:0] phys    [logic [23:0]];
    logic [7:0] ref_mem [logic [23:0]];

    function automatic logic [7:0] init_val(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endfunction
    function automatic logic [7:0] phys_rd(input logic [23:0] a);
        return phys.exists(a) ? phys[a] : init_val(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    always @(negedge clk_in) begin
        mem_rdata = phys_rd(mem_addr);
        if (mem_we) phys[mem_addr] = mem_wdata;
    end

    // reference model: video owns every even visible clock counted from the end of blanking;
    // the write buffer holds WFD entries and drains one per CPU-owned clock
    typedef struct packed {logic [23:0] a; logic [7:0] d;} wr_t;
    wr_t        mf[$], exp_wr[$];
    logic [7:0] exp_rd[$];
    int         vis_idx = 0;
    bit         m_video, m_pop, m_acc, vid_pend = 0, last_video = 0, exp_we = 0;
    logic [7:0] vid_pend_val = 0, exp_vid = 0;
    logic [23:0] last_vaddr = 0;

    always @(posedge clk_in) begin
        if (rst_in) begin
            mf.delete(); exp_wr.delete(); exp_rd.delete();
            ref_mem = phys;
            vis_idx = 0; vid_pend = 0; exp_vid = 0; last_video = 0; exp_we = 0;
        end else begin
            if (vid_pend) exp_vid = vid_pend_val;
            m_video = !vid_active && (vis_idx % 2 == 0);
            vis_idx = vid_active ? 0 : vis_idx + 1;
            m_acc = cpu_we && mf.size() < WFD;
            m_pop = !m_video && mf.size() > 0;
            if (m_pop) exp_wr.push_back(mf.pop_front());
            if (m_acc) begin
                mf.push_back({cpu_addr, cpu_wdata});
                ref_mem[cpu_addr] = cpu_wdata;
            end
            exp_we = m_pop;
            last_video = m_video;
            last_vaddr = vid_addr;
            vid_pend = m_video;
            vid_pend_val = ref_rd(vid_addr);
        end
    end

    // monitor
    wr_t        mw;
    logic [7:0] mr;
    always @(negedge clk_in) begin
        if (!rst_in) begin
            chk("vid_data", vid_data, exp_vid);
            chk("mem_we", mem_we, exp_we);
            chk("cpu_wfull", cpu_wfull, mf.size() == WFD);
            if (last_video) chk("video_mem_addr", mem_addr, last_vaddr);
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: addr %0h data %0h at %0t", mem_addr, mem_wdata, $time);
                end else begin
                    mw = exp_wr.pop_front();
                    chk("write_addr", mem_addr, mw.a);
                    chk("write_data", mem_wdata, mw.d);
                end
            end
            if (cpu_rvalid) begin
                if (exp_rd.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_rvalid: data %0h at %0t", cpu_rdata, $time);
                end else begin
                    mr = exp_rd.pop_front();
                    chk("cpu_rdata", cpu_rdata, mr);
                end
            end
        end
    end

    // driver: 0 = display with incrementing address, 1 = blanking, 2 = random
    int          vmode = 1, lat;
    logic [23:0] vcnt = 24'h10;

    function automatic logic [23:0] rand_vaddr();
        logic [31:0] r;
        r = $urandom;
        return {r[23:12], 4'h0, r[7:0]};
    endfunction

    task automatic drive_vid();
        if (vmode == 0) begin
            vid_active = 0;
            vid_addr = {16'h0, vcnt[7:0]};
            vcnt++;
        end else begin
            vid_active = vmode == 1 ? 1'b1 : $urandom_range(0, 3) == 0;
            vid_addr = rand_vaddr();
        end
    endtask

    task automatic tick();
        drive_vid();
        @(negedge clk_in);
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] d);
        cpu_we = 1; cpu_addr = a; cpu_wdata = d;
        tick();
        cpu_we = 0;
    endtask

    task automatic rd(input logic [23:0] a, input bit hold, output int l);
        exp_rd.push_back(ref_rd(a));
        cpu_re = 1; cpu_addr = a; l = 0;
        do begin
            tick();
            l++;
        end while (!cpu_rvalid && l < 64);
        if (!cpu_rvalid) begin
            tests++; fails++;
            $display("FAIL read_timeout: addr %0h no rvalid within %0d clocks", a, l);
        end
        cpu_re = hold;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        phys[24'h123] = 8'h5A;
        ref_mem[24'h123] = 8'h5A;
        repeat (3) @(negedge clk_in);
        rst_in = 0;
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_vid_data", vid_data, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_cpu_wfull", cpu_wfull, 0);
        vmode = 1;
        repeat (2) tick();
        rd(24'h000123, 1, lat);
        chk("rd_latency", lat, 3);
        chk("rd_data_5a", cpu_rdata, 8'h5A);
        rd(24'h000123, 0, lat);
        chk("rd_held_re_latency", lat, 4);
        tick();
        vmode = 0;
        vcnt = 24'h10;
        repeat (12) tick();
        vmode = 1;
        repeat (3) tick();
        vmode = 0;
        tick();
        chk("first_visible_addr", mem_addr, vid_addr);
        chk("first_visible_we", mem_we, 0);
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            cpu_we = 1; cpu_addr = 24'h000210 + 24'(i); cpu_wdata = 8'($urandom);
            tick();
        end
        cpu_we = 0;
        repeat (10) tick();
        vmode = 1;
        wr(24'h000200, 8'hA5);
        rd(24'h000200, 0, lat);
        chk("raw_data_a5", cpu_rdata, 8'hA5);
        vmode = 0;
        for (int i = 0; i < 3; i++) wr(24'h000200 + 24'(i), 8'($urandom));
        rd(24'h000201, 0, lat);
        for (int i = 0; i < 10; i++) rd(24'h000210 + 24'(i), 0, lat);
        vmode = 2;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 2) != 0) wr(24'h000200 + 24'($urandom_range(0, 31)), 8'($urandom));
            else rd(24'h000200 + 24'($urandom_range(0, 31)), 0, lat);
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 4)) tick();
        end
        vmode = 0;
        for (int i = 0; i < 4; i++) wr(24'h000220 + 24'(i), 8'($urandom));
        cpu_re = 1; cpu_addr = 24'h000205;
        tick();
        #2 rst_in = 1;
        #1;
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_mem_wdata", mem_wdata, 0);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_vid_data", vid_data, 0);
        chk("midrst_cpu_rdata", cpu_rdata, 0);
        chk("midrst_cpu_rvalid", cpu_rvalid, 0);
        chk("midrst_cpu_wfull", cpu_wfull, 0);
        cpu_re = 0;
        @(negedge clk_in);
        rst_in = 0;
        vmode = 1;
        repeat (10) tick();
        rd(24'h000205, 0, lat);
        rd(24'h000221, 0, lat);
        repeat (10) tick();
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
